// File: rtl/sgd_x_mem_write_splitter.sv
// sgd_x_mem_write_splitter
// Takes model write-back jobs (start/addr/length) and the matching 512-bit
// beat stream. Issues memory write bursts that never cross a MAX_BURST_BYTES
// boundary. Beats are buffered in a FIFO, and an almost-full flag throttles
// the upstream stage.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, addr, length       job request; a rising start or an addr change is a new job
//   data_in, data_in_valid    beat input (no ready; upstream obeys almost-full)
//   data_in_almost_full       registered FIFO occupancy >= FIFO_DEPTH-AF_SLACK
//   mem_cmd_*                 burst command channel (valid/ready, addr, byte len)
//   mem_data*                 burst data channel (valid/ready/last)
//   busy                      a job is active or pending
//   err_unaligned             sticky: accepted job had nonzero addr/length low bits
//   err_overflow              sticky: beat lost at full FIFO, or job lost at full pending slot
module sgd_x_mem_write_splitter #(
  parameter int unsigned DATA_W          = 512,
  parameter int unsigned MAX_BURST_BYTES = 4096,
  parameter int unsigned FIFO_DEPTH      = 64,
  parameter int unsigned AF_SLACK        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [63:0]       addr,
  input  logic [31:0]       length,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              data_in_almost_full,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [63:0]       mem_cmd_addr,
  output logic [31:0]       mem_cmd_len,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_data_valid,
  input  logic              mem_data_ready,
  output logic              mem_data_last,
  output logic              busy,
  output logic              err_unaligned,
  output logic              err_overflow
);

  localparam int unsigned BW     = $clog2(MAX_BURST_BYTES);
  localparam int unsigned BCW    = BW - 5;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned AF_THR = FIFO_DEPTH - AF_SLACK;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} cmd_state_t;

  // Burst length: the remaining bytes, limited by the room left before the next boundary.
  function automatic logic [31:0] f_burst_len(input logic [BW-1:0] off, input logic [31:0] rem);
    logic [31:0] room;
    room = 32'(MAX_BURST_BYTES) - 32'(off);
    return (rem < room) ? rem : room;
  endfunction

  cmd_state_t          r_state, w_state_nxt;
  logic                r_start_q;
  logic [63:0]         r_addr_q;
  logic                r_pend_valid;
  logic [63:0]         r_pend_addr;
  logic [31:0]         r_pend_len;
  logic [63:0]         r_c_addr, r_d_addr;
  logic [31:0]         r_c_rem, r_d_rem;
  logic [BCW-1:0]      r_d_beat;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                r_af, r_err_unal, r_err_ovf;

  logic                w_accept, w_job_unal, w_idle, w_act, w_act_pend, w_act_new;
  logic [63:0]         w_job_addr, w_act_addr;
  logic [31:0]         w_job_len, w_act_len, w_cmd_len, w_d_len;
  logic [BCW-1:0]      w_d_beats, w_beat_nxt;
  logic                w_cmd_hs, w_full, w_push, w_pop, w_dvalid, w_dlast;

  assign w_accept   = start & (~r_start_q | (addr != r_addr_q));
  assign w_job_addr = {addr[63:6], 6'b0};
  assign w_job_len  = {length[31:6], 6'b0};
  assign w_job_unal = (addr[5:0] != 6'd0) | (length[5:0] != 6'd0);

  // Both sides finished; a pending job has priority over a newly accepted one.
  assign w_idle     = (r_state == S_IDLE) & (r_d_rem == '0);
  assign w_act_pend = w_idle & r_pend_valid;
  assign w_act_new  = w_idle & ~r_pend_valid & w_accept;
  assign w_act      = w_act_pend | w_act_new;
  assign w_act_addr = w_act_pend ? r_pend_addr : w_job_addr;
  assign w_act_len  = w_act_pend ? r_pend_len  : w_job_len;

  assign w_cmd_len  = f_burst_len(r_c_addr[BW-1:0], r_c_rem);
  assign w_cmd_hs   = mem_cmd_valid & mem_cmd_ready;

  assign w_d_len    = f_burst_len(r_d_addr[BW-1:0], r_d_rem);
  assign w_d_beats  = w_d_len[BW:6];
  assign w_beat_nxt = r_d_beat + BCW'(1);
  assign w_dlast    = (w_beat_nxt == w_d_beats);

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_dvalid   = (r_d_rem != '0) & (r_count != '0);
  assign w_pop      = w_dvalid & mem_data_ready;
  assign w_push     = data_in_valid & (~w_full | w_pop);

  // Job acceptance, pending slot and sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_q    <= 1'b0;
      r_addr_q     <= '0;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_len   <= '0;
      r_err_unal   <= 1'b0;
      r_err_ovf    <= 1'b0;
    end else begin
      r_start_q <= start;
      r_addr_q  <= addr;
      if (w_accept & w_job_unal)
        r_err_unal <= 1'b1;
      if (data_in_valid & w_full & ~w_pop)
        r_err_ovf <= 1'b1;
      // The slot frees in the same cycle its job activates, so it can take a new job then.
      if (w_accept & ~w_act_new) begin
        if (~r_pend_valid | w_act_pend) begin
          r_pend_valid <= 1'b1;
          r_pend_addr  <= w_job_addr;
          r_pend_len   <= w_job_len;
        end else begin
          r_err_ovf <= 1'b1;
        end
      end else if (w_act_pend) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // Command FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_act & (w_act_len != '0))           w_state_nxt = S_ISSUE;
      S_ISSUE: if (mem_cmd_ready & (r_c_rem == w_cmd_len)) w_state_nxt = S_DONE;
      S_DONE:  if (r_d_rem == '0)                       w_state_nxt = S_IDLE;
      default:                                          w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_cmd_valid = (r_state == S_ISSUE);
    mem_cmd_addr  = mem_cmd_valid ? r_c_addr  : '0;
    mem_cmd_len   = mem_cmd_valid ? w_cmd_len : '0;
  end

  // Command side address/remaining bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c_addr <= '0;
      r_c_rem  <= '0;
    end else if (w_act) begin
      r_c_addr <= w_act_addr;
      r_c_rem  <= w_act_len;
    end else if (w_cmd_hs) begin
      r_c_addr <= r_c_addr + 64'(w_cmd_len);
      r_c_rem  <= r_c_rem - w_cmd_len;
    end
  end

  // Data side: an independent copy of the burst split, advanced per popped beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_addr <= '0;
      r_d_rem  <= '0;
      r_d_beat <= '0;
    end else if (w_act) begin
      r_d_addr <= w_act_addr;
      r_d_rem  <= w_act_len;
      r_d_beat <= '0;
    end else if (w_pop) begin
      if (w_dlast) begin
        r_d_addr <= r_d_addr + 64'(w_d_len);
        r_d_rem  <= r_d_rem - w_d_len;
        r_d_beat <= '0;
      end else begin
        r_d_beat <= w_beat_nxt;
      end
    end
  end

  // Beat FIFO; the head is read straight from the storage registers
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_af     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_af <= (r_count >= CW'(AF_THR));
    end
  end

  assign mem_data_valid      = w_dvalid;
  assign mem_data            = w_dvalid ? r_mem[r_rd_ptr] : '0;
  assign mem_data_last       = w_dvalid & w_dlast;
  assign data_in_almost_full = r_af;
  assign busy                = (r_state != S_IDLE) | (r_d_rem != '0) | r_pend_valid;
  assign err_unaligned       = r_err_unal;
  assign err_overflow        = r_err_ovf;

endmodule
